// File: rtl/star_pkg.sv
// Shared types and constants for the star collector slice.
package star_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CLEAR
  } collect_state_t;

  localparam logic [11:0] BCD_MAX       = 12'h999;
  localparam logic [11:0] BONUS_BCD     = 12'h100;
  localparam int          DEF_NUM_STARS = 5;

endpackage

// File: rtl/star_collector_bcd_add_sat.sv
// Combinational 3-digit BCD adder. Each digit gets a +6 correction, and a
// carry out of the hundreds digit saturates the result to BCD_MAX.
module bcd_add_sat
  import star_pkg::*;
(
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [11:0] sum
);

  logic [4:0] digit;
  logic       carry;

  // NOTE: every variable written here is given a value first, so no path through the block can infer a latch.
  always_comb begin
    sum   = '0;
    digit = '0;
    carry = 1'b0;
    for (int i = 0; i < 3; i++) begin
      digit = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, carry};
      if (digit > 5'd9) begin
        digit = digit + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = digit[3:0];
    end
    if (carry) sum = BCD_MAX;
  end

endmodule

// File: rtl/star_collector.sv
// Credits star touch pulses into a mask, a count, a saturating BCD score and a
// flash strobe, then flags level clear. Optional clear bonus: STAR_COLLECTOR_BONUS_EN.
module star_collector
  import star_pkg::*;
#(
  parameter int          NUM_STARS    = DEF_NUM_STARS,
  parameter int          POINTS       = 5,
  parameter logic [15:0] FLASH_CYCLES = 16'd50000,
  localparam int         CW           = $clog2(NUM_STARS + 1)
) (
  input  logic                 sys_clk,
  input  logic                 RST,
  input  logic                 game_start,
  input  logic [NUM_STARS-1:0] touch_star,
  output logic [NUM_STARS-1:0] collected_mask,
  output logic [CW-1:0]        star_count,
  output logic [11:0]          score_bcd,
  output logic                 flash,
  output logic                 level_clear
);

  localparam logic [11:0] POINTS_BCD = 12'(POINTS);

  collect_state_t       state_q, state_d;
  logic [NUM_STARS-1:0] pending_q, pending_d;
  logic [NUM_STARS-1:0] svc;
  logic [NUM_STARS-1:0] mask_d;
  logic [CW-1:0]        count_d;
  logic [11:0]          score_d, score_inc;
  logic [15:0]          timer_q, timer_d;

  // Isolate the lowest pending star; only one star is credited per edge.
  assign svc = pending_q & (~pending_q + NUM_STARS'(1));

  bcd_add_sat u_add_points (
    .a   (score_bcd),
    .b   (POINTS_BCD),
    .sum (score_inc)
  );

`ifdef STAR_COLLECTOR_BONUS_EN
  logic [11:0] score_bonus;

  bcd_add_sat u_add_bonus (
    .a   (score_bcd),
    .b   (BONUS_BCD),
    .sum (score_bonus)
  );
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mask_d    = collected_mask;
    count_d   = star_count;
    score_d   = score_bcd;
    timer_d   = (timer_q != 16'd0) ? timer_q - 16'd1 : 16'd0;

    if (game_start) begin
      state_d   = RUN;
      pending_d = '0;
      mask_d    = '0;
      count_d   = '0;
      score_d   = '0;
      timer_d   = '0;
    end else if (state_q == RUN) begin
      pending_d = (pending_q & ~svc) | (touch_star & ~collected_mask & ~pending_q);
      if (pending_q != '0) begin
        mask_d  = collected_mask | svc;
        count_d = star_count + CW'(1);
        score_d = score_inc;
        timer_d = FLASH_CYCLES;
      end else if (&collected_mask) begin
        state_d = CLEAR;
`ifdef STAR_COLLECTOR_BONUS_EN
        score_d = score_bonus;
`endif
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      collected_mask <= '0;
      star_count     <= '0;
      score_bcd      <= '0;
      timer_q        <= '0;
      flash          <= 1'b0;
      level_clear    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      collected_mask <= mask_d;
      star_count     <= count_d;
      score_bcd      <= score_d;
      timer_q        <= timer_d;
      flash          <= (timer_d != 16'd0);
      level_clear    <= (state_d == CLEAR);
    end
  end

endmodule

// File: tb/tb_star_collector.sv
// Directed bench for star_collector with default parameters; honours STAR_COLLECTOR_BONUS_EN.
module tb_star_collector;

  logic        sys_clk = 1'b0;
  logic        RST = 1'b1;
  logic        game_start = 1'b0;
  logic [4:0]  touch_star = '0;
  logic [4:0]  collected_mask;
  logic [2:0]  star_count;
  logic [11:0] score_bcd;
  logic        flash;
  logic        level_clear;

  int total = 0;
  int bad   = 0;

`ifdef STAR_COLLECTOR_BONUS_EN
  localparam logic [11:0] CLEAR_SCORE = 12'h125;
`else
  localparam logic [11:0] CLEAR_SCORE = 12'h025;
`endif

  star_collector dut (
    .sys_clk        (sys_clk),
    .RST            (RST),
    .game_start     (game_start),
    .touch_star     (touch_star),
    .collected_mask (collected_mask),
    .star_count     (star_count),
    .score_bcd      (score_bcd),
    .flash          (flash),
    .level_clear    (level_clear)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] mask, input logic [2:0] cnt,
                           input logic [11:0] score, input logic fl, input logic lc);
    check({tag, ".mask"}, 32'(collected_mask), 32'(mask));
    check({tag, ".count"}, 32'(star_count), 32'(cnt));
    check({tag, ".score"}, 32'(score_bcd), 32'(score));
    check({tag, ".flash"}, 32'(flash), 32'(fl));
    check({tag, ".clear"}, 32'(level_clear), 32'(lc));
  endtask

  task automatic pulse_start();
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
  endtask

  task automatic touch(input logic [4:0] t);
    touch_star = t;
    tick();
    touch_star = '0;
  endtask

  initial begin
    // Reset, then touches in IDLE are ignored.
    tick(2);
    check_all("reset", 5'b0, 3'd0, 12'h000, 1'b0, 1'b0);
    RST = 1'b0;
    tick();
    touch(5'b00001);
    tick(2);
    check_all("idle_touch", 5'b0, 3'd0, 12'h000, 1'b0, 1'b0);

    // Single touch: captured on one edge, credited on the next.
    pulse_start();
    touch(5'b00100);
    check("single.latency_count", 32'(star_count), 32'd0);
    tick();
    check_all("single", 5'b00100, 3'd1, 12'h005, 1'b1, 1'b0);
    tick(49999);
    check("flash.last_high", 32'(flash), 32'd1);
    tick();
    check("flash.fall", 32'(flash), 32'd0);

    // Simultaneous touches credited in ascending order; repeat on bit 0 ignored.
    pulse_start();
    touch(5'b10011);
    touch(5'b00001);
    check("multi.b0.mask", 32'(collected_mask), 32'h01);
    check("multi.b0.count", 32'(star_count), 32'd1);
    tick();
    check("multi.b1.mask", 32'(collected_mask), 32'h03);
    check("multi.b1.count", 32'(star_count), 32'd2);
    tick();
    check_all("multi.b4", 5'b10011, 3'd3, 12'h015, 1'b1, 1'b0);
    tick();
    check("multi.no_repeat", 32'(star_count), 32'd3);

    // Remaining stars, then level clear one edge after the last credit.
    touch(5'b01100);
    tick();
    check("clr.b2.count", 32'(star_count), 32'd4);
    check("clr.b2.score", 32'(score_bcd), 32'h020);
    tick();
    check_all("clr.last", 5'b11111, 3'd5, 12'h025, 1'b1, 1'b0);
    tick();
    check_all("clr.flag", 5'b11111, 3'd5, CLEAR_SCORE, 1'b1, 1'b1);
    touch_star = 5'b11111;
    tick(3);
    touch_star = '0;
    tick();
    check_all("clr.frozen", 5'b11111, 3'd5, CLEAR_SCORE, 1'b1, 1'b1);

    // game_start wins over a same-cycle touch while pending is non-empty.
    pulse_start();
    check("restart.clear_falls", 32'(level_clear), 32'd0);
    touch(5'b00011);
    game_start = 1'b1;
    touch_star = 5'b01000;
    tick();
    game_start = 1'b0;
    touch_star = '0;
    check_all("start_prio", 5'b0, 3'd0, 12'h000, 1'b0, 1'b0);
    tick(3);
    check_all("start_prio.drop", 5'b0, 3'd0, 12'h000, 1'b0, 1'b0);
    touch(5'b00001);
    tick();
    check_all("start_prio.run", 5'b00001, 3'd1, 12'h005, 1'b1, 1'b0);

    // Saturation: preload 997, one credit of 5 saturates at 999, and stays there.
    force dut.score_bcd = 12'h997;
    touch_star = 5'b00010;
    tick();
    release dut.score_bcd;
    touch_star = '0;
    tick();
    check("sat.score", 32'(score_bcd), 32'h999);
    check("sat.count", 32'(star_count), 32'd2);
    touch(5'b00100);
    tick();
    check("sat.hold", 32'(score_bcd), 32'h999);
    check("sat.hold_count", 32'(star_count), 32'd3);

    // Asynchronous reset mid-queue clears immediately; the queued star is lost.
    touch(5'b11000);
    tick();
    check("rst.pre_count", 32'(star_count), 32'd4);
    #2 RST = 1'b1;
    #1;
    check_all("rst.async", 5'b0, 3'd0, 12'h000, 1'b0, 1'b0);
    @(negedge sys_clk);
    RST = 1'b0;
    tick();
    touch(5'b10000);
    tick(2);
    check_all("rst.idle", 5'b0, 3'd0, 12'h000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/star_collector.md
# star_collector

Aggregates the one-cycle `touch` pulses from all star objects into a collected-star count, a 3-digit BCD score, a per-collect flash strobe and a level-clear flag. Sits directly downstream of the star object modules and upstream of the HUD/score renderer and the level sequencer. Queues simultaneous touches so that every distinct star is credited exactly once.

## Interface
Parameters:
- `NUM_STARS`, 5: number of star objects feeding `touch_star`.
- `POINTS`, 5: BCD points added per star. Legal range 1..9.
- `FLASH_CYCLES`, 16'd50000: duration of the `flash` strobe, in `sys_clk` cycles.

Ports (one clock; reset is asynchronous and active-high):
- `sys_clk` in 1: system clock.
- `RST` in 1: asynchronous, active-high reset.
- `game_start` in 1: one-cycle pulse. Clears all state and arms collection.
- `touch_star` in NUM_STARS: per-star touch pulses. Bit i comes from star i and is already gated by that star's enable.
- `collected_mask` out NUM_STARS: sticky record of which stars have been credited.
- `star_count` out $clog2(NUM_STARS+1): number of credited stars.
- `score_bcd` out 12: three BCD digits; [11:8] is hundreds.
- `flash` out 1: high while the flash timer is non-zero.
- `level_clear` out 1: high while in state CLEAR.

## Operation
- States:
  - IDLE: after reset. `touch_star` is ignored.
  - RUN: collecting.
  - CLEAR: every star credited.
- Transitions:
  - IDLE→RUN on `game_start`.
  - RUN→CLEAR when `collected_mask` is all ones and `pending` is empty.
  - Any state→RUN on `game_start`.
- `game_start` action:
  - Zeroes `pending`, `collected_mask`, `star_count`, `score_bcd` and the flash timer.
  - Has priority over any `touch_star` sampled in the same cycle; those touches are dropped.
- Capture (RUN only): `pending <= (pending & ~svc) | (touch_star & ~collected_mask & ~pending)`.
  - Repeat touches on a star already credited or already pending are ignored.
- Service (RUN only): each cycle where `pending` ≠ 0, the lowest set bit `svc` is serviced. Servicing means:
  - set that bit in `collected_mask`;
  - `star_count` += 1;
  - `score_bcd` += POINTS, as a BCD add saturating at 12'h999;
  - load the flash timer with FLASH_CYCLES.
- Flash timer:
  - 16-bit down-counter, decrements to 0 and stops there.
  - A reload while it is non-zero restarts it at FLASH_CYCLES.
- CLEAR: `touch_star` is ignored; `score_bcd` and `collected_mask` are frozen.
- Reset values: IDLE; `pending`, `collected_mask`, `star_count`, `score_bcd`, flash timer = 0; `flash` = 0; `level_clear` = 0.
- Reset mid-operation discards `pending` without crediting it.

## Timing
- All outputs are registered.
- A touch high during cycle t is captured at the edge ending t. It is serviced, and its outputs updated, at the edge ending t+1 when `pending` holds no lower-indexed bit.
- k simultaneous new touches are credited on k consecutive edges in ascending index order. `star_count` rises by exactly 1 per edge.
- `flash` rises on the same edge as the `star_count` increment. It stays high for FLASH_CYCLES cycles after the last service.
- `level_clear` rises on the edge after the final service.
- `level_clear` falls on the edge that samples `game_start`.

## Configuration
- `STAR_COLLECTOR_BONUS_EN` defined:
  - On the RUN→CLEAR transition edge, `score_bcd` additionally gains 12'h100, saturating at 12'h999.
  - The bonus is applied once per level.
- `STAR_COLLECTOR_BONUS_EN` undefined: no bonus; the CLEAR entry leaves `score_bcd` unchanged.

## Structure
- Package `star_pkg`:
  - state enum `collect_state_t` {IDLE, RUN, CLEAR};
  - `BCD_MAX` = 12'h999;
  - `BONUS_BCD` = 12'h100;
  - default `NUM_STARS`.
- Sub-module `bcd_add_sat`: combinational 3-digit BCD adder (12-bit a, 12-bit b) with per-digit +6 correction and saturation to `BCD_MAX`. It is used for both the per-star add and the bonus add.
- The lowest-set-bit priority select stays inline.

## Test plan
- Reset then `touch_star`=5'b00001 while in IDLE → all outputs stay 0.
- `game_start`, then `touch_star`=5'b00100 for 1 cycle → two edges later `star_count`=1, `score_bcd`=12'h005, `collected_mask`=5'b00100, `flash`=1 for 50000 cycles.
- Touch 5'b10011 in one cycle, then 5'b00001 again → credited as bits 0, 1, 4 on consecutive edges; `star_count` reaches 3, `score_bcd`=12'h015; the repeat on bit 0 is ignored.
- Collect all 5 stars → `level_clear`=1 one edge after the last credit. `score_bcd`=12'h025 without the macro, 12'h125 with `STAR_COLLECTOR_BONUS_EN`. Further touches do not change any output.
- `game_start` asserted in the same cycle as `touch_star`=5'b01000, with pending non-empty → all counters clear and state is RUN; the touch is not credited.
- Preload `score_bcd` near 12'h997 via a bench force, then service one star with POINTS=5 → `score_bcd`=12'h999 (saturated). Also assert `RST` mid-queue → everything returns to 0 / IDLE immediately, without waiting for a clock edge.
